// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment table, blank pattern and scan state type
package seg7_pkg;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  typedef enum logic {BLANK, DRIVE} state_t;
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: hex nibble to active-low segments, bit 6 = g
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  assign o_seg = HEX_SEG[i_nib];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 7-seg scanner with blanking gap and frame-synchronous double buffer
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              cathode,
  output logic                    dp,
  output logic                    frame_done
);
  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt;
  state_t r_state, w_state_nxt;
  logic w_slot_end, w_frame_end, w_on, w_accept;
  logic [4*NUM_DIGITS-1:0] r_act_data, r_pen_data;
  logic [NUM_DIGITS-1:0] r_act_dp, r_act_en, r_pen_dp, r_pen_en;
  logic r_pen_flag;
  logic [6:0] w_seg;
  assign load_ready = ~r_pen_flag;
  assign w_accept = load_valid && load_ready;
  seg7_hex_decode u_dec (.i_nib(r_act_data[4*r_idx +: 4]), .o_seg(w_seg));
  always_comb begin
    w_slot_end  = r_cnt == CW'(SLOT_CYCLES - 1);
    w_frame_end = w_slot_end && r_idx == IW'(NUM_DIGITS - 1);
    w_cnt_nxt   = w_slot_end ? '0 : r_cnt + 1'b1;
    w_idx_nxt   = w_frame_end ? '0 : w_slot_end ? r_idx + 1'b1 : r_idx;
    w_state_nxt = r_state == BLANK ? (w_cnt_nxt >= CW'(BLANK_CYCLES) ? DRIVE : BLANK)
                                   : (w_slot_end ? BLANK : DRIVE);
    w_on        = r_state == DRIVE && r_act_en[r_idx];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_state <= BLANK;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_state <= w_state_nxt;
    end
  end
  // pins are registered from the current counter/state so slot changes never glitch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      anode      <= '1;
      cathode    <= SEG_OFF;
      dp         <= 1'b1;
      frame_done <= 1'b0;
      r_act_data <= '0;
      r_act_dp   <= '0;
      r_act_en   <= '0;
      r_pen_data <= '0;
      r_pen_dp   <= '0;
      r_pen_en   <= '0;
      r_pen_flag <= 1'b0;
    end else begin
      anode      <= w_on ? ~(NUM_DIGITS'(1) << r_idx) : '1;
      cathode    <= w_on ? w_seg : SEG_OFF;
      dp         <= ~(w_on && r_act_dp[r_idx]);
      frame_done <= w_frame_end;
      if (w_frame_end && r_pen_flag) begin
        r_act_data <= r_pen_data;
        r_act_dp   <= r_pen_dp;
        r_act_en   <= r_pen_en;
      end
      if (w_accept) begin
        r_pen_data <= digit_data;
        r_pen_dp   <= dp_in;
        r_pen_en   <= digit_en;
      end
      r_pen_flag <= w_accept || (r_pen_flag && !w_frame_end);
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: frame-position reference model plus directed and random scan/load checks
module tb_seg7_scan_ctrl;
  localparam int N = 8, S = 8, B = 2, F = N * S;
  logic clk = 0, rst_n = 0, load_valid = 0, load_ready;
  logic [4*N-1:0] digit_data = '0;
  logic [N-1:0] dp_in = '0, digit_en = '0, anode;
  logic [6:0] cathode;
  logic dp, frame_done;
  int tests = 0, fails = 0;
  typedef struct {logic [3:0] nib; logic [6:0] seg;} hex_vec_t;
  hex_vec_t hv [16];
  logic [6:0] segs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int m_e;
  logic [31:0] m_act_d, m_pen_d;
  logic [7:0] m_act_p, m_act_e, m_pen_p, m_pen_e;
  logic m_pf;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.NUM_DIGITS(N), .SLOT_CYCLES(S), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .digit_data(digit_data), .dp_in(dp_in), .digit_en(digit_en),
    .anode(anode), .cathode(cathode), .dp(dp), .frame_done(frame_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (frame pos %0d)", name, act, exp, m_e % F);
    end
  endtask

  // one clock: expected pins derive from the frame position and the model's active frame
  task automatic tick();
    int q, idx, off;
    logic on, ef, ed, acc;
    logic [7:0] ea, cp, ce;
    logic [6:0] ec;
    logic [31:0] cd;
    q = m_e % F; idx = q / S; off = q % S;
    on = off >= B && m_act_e[idx];
    ea = on ? ~(8'(1) << idx) : 8'hFF;
    ec = on ? hv[m_act_d[4*idx +: 4]].seg : 7'h7F;
    ed = on ? ~m_act_p[idx] : 1'b1;
    ef = q == F - 1;
    acc = load_valid && !m_pf; cd = digit_data; cp = dp_in; ce = digit_en;
    @(posedge clk); #1;
    if (ef && m_pf) begin
      m_act_d = m_pen_d; m_act_p = m_pen_p; m_act_e = m_pen_e; m_pf = 0;
    end
    if (acc) begin
      m_pen_d = cd; m_pen_p = cp; m_pen_e = ce; m_pf = 1;
    end
    m_e++;
    check("pins", 32'({anode, cathode, dp, frame_done}), 32'({ea, ec, ed, ef}));
    check("load_ready", 32'(load_ready), 32'(!m_pf));
  endtask

  task automatic do_reset(input int n);
    rst_n = 0;
    repeat (n) begin @(posedge clk); #1; end
    check("rst_pins", 32'({anode, cathode, dp, frame_done}), 32'({8'hFF, 7'h7F, 1'b1, 1'b0}));
    check("rst_ready", 32'(load_ready), 32'(1));
    rst_n = 1;
    m_e = 0; m_act_d = 0; m_act_p = 0; m_act_e = 0;
    m_pen_d = 0; m_pen_p = 0; m_pen_e = 0; m_pf = 0;
  endtask

  task automatic offer(input logic [31:0] d, input logic [7:0] p, input logic [7:0] en);
    bit got = 0;
    digit_data = d; dp_in = p; digit_en = en; load_valid = 1;
    for (int i = 0; i < 4 * F && !got; i++) begin
      got = !m_pf;
      tick();
    end
    check("offer_accepted", 32'(got), 32'(1));
    load_valid = 0;
  endtask

  task automatic run_until(input int t);
    int i = 0;
    do begin tick(); i++; end while (m_e % F != t && i < 2 * F);
    check("run_until_pos", 32'(m_e % F), 32'(t));
  endtask

  initial begin
    int last, gap;
    for (int i = 0; i < 16; i++) begin hv[i].nib = 4'(i); hv[i].seg = segs[i]; end
    do_reset(2);
    offer(32'h76543210, 8'h01, 8'hFF);
    run_until(0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k >= 3 && k <= 8) begin
        check("d0_anode", 32'(anode), 32'(8'hFE));
        check("d0_cathode", 32'(cathode), 32'(7'h40));
        check("d0_dp", 32'(dp), 32'(0));
      end else if (k <= 2) check("d0_blank", 32'(anode), 32'(8'hFF));
      if (k == 11) check("d1_cathode", 32'(cathode), 32'(7'h79));
    end
    last = -1; gap = -1;
    for (int i = 0; i < 3 * F; i++) begin
      tick();
      if (frame_done) begin
        if (last >= 0) begin gap = i - last; break; end
        last = i;
      end
    end
    check("fd_period", 32'(gap), 32'(F));
    offer(32'hFEDCBA98, 8'hAA, 8'h0F);
    run_until(0);
    run_until(5 * S + 5);
    check("masked_anode", 32'(anode), 32'(8'hFF));
    check("masked_cathode", 32'(cathode), 32'(7'h7F));
    offer(32'h88888888, 8'h00, 8'hFF);
    check("ready_low", 32'(load_ready), 32'(0));
    offer(32'h11111111, 8'h00, 8'hFF);
    run_until(3);
    check("first_load_shown", 32'(cathode), 32'(7'h00));
    run_until(0);
    run_until(3);
    check("second_load_shown", 32'(cathode), 32'(7'h79));
    run_until(F - 1);
    digit_data = 32'h0; dp_in = 8'h00; digit_en = 8'hFF; load_valid = 1;
    tick();
    load_valid = 0;
    check("coincident_ready", 32'(load_ready), 32'(0));
    run_until(3);
    check("coincident_old", 32'(cathode), 32'(7'h79));
    run_until(0);
    run_until(3);
    check("coincident_new", 32'(cathode), 32'(7'h40));
    offer(32'h22222222, 8'hFF, 8'hFF);
    run_until(S + 5);
    do_reset(1);
    repeat (2 * F) tick();
    for (int i = 0; i < 16; i++) begin
      offer({8{hv[i].nib}}, 8'h00, 8'hFF);
      run_until(0);
      run_until(3 + S * (i % 8));
      check("hex", 32'(cathode), 32'(hv[i].seg));
    end
    for (int i = 0; i < 700; i++) begin
      load_valid = $urandom_range(0, 3) == 0;
      digit_data = $urandom;
      dp_in = 8'($urandom);
      digit_en = 8'($urandom);
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
